motor_drive_monitor: RTL and testbench

//   Recovers the signed 11-bit drive command for each side from the fwd/rev PWM pin

---
 rtl/motor_drive_monitor_if.sv | 26 ++
 rtl/motor_drive_monitor.sv | 155 +++++++++++++++
 tb/tb_motor_drive_monitor.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_drive_monitor_if.sv
// Bus between the motor PWM pins and the drive monitor.
// The master drives enable and pins; the slave returns the recovered commands.
interface motor_drive_monitor_if;
   logic        en;
   logic        fwd_lft;
   logic        rev_lft;
   logic        fwd_rht;
   logic        rev_rht;
   logic [10:0] lft_meas;
   logic [10:0] rht_meas;
   logic        brk_lft;
   logic        brk_rht;
   logic        flt_lft;
   logic        flt_rht;
   logic        meas_vld;

   modport master (
      output en, fwd_lft, rev_lft, fwd_rht, rev_rht,
      input  lft_meas, rht_meas, brk_lft, brk_rht, flt_lft, flt_rht, meas_vld
   );

   modport slave (
      input  en, fwd_lft, rev_lft, fwd_rht, rev_rht,
      output lft_meas, rht_meas, brk_lft, brk_rht, flt_lft, flt_rht, meas_vld
   );
endinterface

// File: rtl/motor_drive_monitor.sv
// Recovers signed 11-bit drive commands from fwd/rev PWM pin pairs by counting
// high cycles over one full PWM period and classifying each window.
module motor_drive_monitor #(
   parameter int unsigned PERIOD = 1024
) (
   input logic                  clk,
   input logic                  rst_n,
   motor_drive_monitor_if.slave bus
);
   localparam int unsigned CW = $clog2(PERIOD + 1);
   localparam int unsigned WW = $clog2(PERIOD);
   localparam int unsigned MW = 11;
   localparam int unsigned SW = 12;

   typedef enum logic [1:0] {IDLE, SETTLE, MEAS} state_e;

   state_e          state_q, state_d;
   logic [WW-1:0]   wcnt_q, wcnt_d;
   logic [CW-1:0]   cf_lft_q, cf_lft_d, cr_lft_q, cr_lft_d;
   logic [CW-1:0]   cf_rht_q, cf_rht_d, cr_rht_q, cr_rht_d;
   logic [MW-1:0]   lft_meas_q, lft_meas_d, rht_meas_q, rht_meas_d;
   logic            brk_lft_q, brk_lft_d, brk_rht_q, brk_rht_d;
   logic            flt_lft_q, flt_lft_d, flt_rht_q, flt_rht_d;
   logic            vld_q, vld_d;

   logic            wend_c;
   logic [CW-1:0]   cf_lft_c, cr_lft_c, cf_rht_c, cr_rht_c;

   // Returns {meas, brk, flt} for one side at window end.
   function automatic logic [MW+1:0] classify(input logic [CW-1:0] cf,
                                               input logic [CW-1:0] cr,
                                               input logic [MW-1:0] prev);
      logic [SW-1:0]   f;
      logic [SW-1:0]   r;
      logic [MW-2:0]   mag;
      logic [MW+1:0]   res;
      f   = SW'(cf);
      r   = SW'(cr);
      mag = '0;
      if ((cf == CW'(PERIOD)) && (cr == CW'(PERIOD))) begin
         res = {MW'(0), 1'b1, 1'b0};
      end else if (r == SW'(0)) begin
         mag = (f > SW'(1023)) ? 10'd1023 : f[MW-2:0];
         res = {{1'b0, mag}, 2'b00};
      end else if (f == SW'(0)) begin
         mag = (r > SW'(1023)) ? 10'd1023 : r[MW-2:0];
         res = {MW'(0) - {1'b0, mag}, 2'b00};
      end else begin
         res = {prev, 2'b01};
      end
      return res;
   endfunction

   // Running counts including the current sample.
   assign wend_c   = (wcnt_q == WW'(PERIOD - 1));
   assign cf_lft_c = cf_lft_q + CW'(bus.fwd_lft);
   assign cr_lft_c = cr_lft_q + CW'(bus.rev_lft);
   assign cf_rht_c = cf_rht_q + CW'(bus.fwd_rht);
   assign cr_rht_c = cr_rht_q + CW'(bus.rev_rht);

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      cf_lft_d   = cf_lft_q;
      cr_lft_d   = cr_lft_q;
      cf_rht_d   = cf_rht_q;
      cr_rht_d   = cr_rht_q;
      lft_meas_d = lft_meas_q;
      rht_meas_d = rht_meas_q;
      brk_lft_d  = brk_lft_q;
      brk_rht_d  = brk_rht_q;
      flt_lft_d  = flt_lft_q;
      flt_rht_d  = flt_rht_q;
      vld_d      = 1'b0;
      case (state_q)
         IDLE: begin
            wcnt_d   = '0;
            cf_lft_d = '0;
            cr_lft_d = '0;
            cf_rht_d = '0;
            cr_rht_d = '0;
            if (bus.en) state_d = SETTLE;
         end
         SETTLE, MEAS: begin
            if (!bus.en) begin
               state_d  = IDLE;
               wcnt_d   = '0;
               cf_lft_d = '0;
               cr_lft_d = '0;
               cf_rht_d = '0;
               cr_rht_d = '0;
            end else if (wend_c) begin
               state_d  = MEAS;
               wcnt_d   = '0;
               cf_lft_d = '0;
               cr_lft_d = '0;
               cf_rht_d = '0;
               cr_rht_d = '0;
               if (state_q == MEAS) begin
                  {lft_meas_d, brk_lft_d, flt_lft_d} = classify(cf_lft_c, cr_lft_c, lft_meas_q);
                  {rht_meas_d, brk_rht_d, flt_rht_d} = classify(cf_rht_c, cr_rht_c, rht_meas_q);
                  vld_d = 1'b1;
               end
            end else begin
               wcnt_d   = wcnt_q + WW'(1);
               cf_lft_d = cf_lft_c;
               cr_lft_d = cr_lft_c;
               cf_rht_d = cf_rht_c;
               cr_rht_d = cr_rht_c;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         cf_lft_q   <= '0;
         cr_lft_q   <= '0;
         cf_rht_q   <= '0;
         cr_rht_q   <= '0;
         lft_meas_q <= '0;
         rht_meas_q <= '0;
         brk_lft_q  <= 1'b1;
         brk_rht_q  <= 1'b1;
         flt_lft_q  <= 1'b0;
         flt_rht_q  <= 1'b0;
         vld_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         cf_lft_q   <= cf_lft_d;
         cr_lft_q   <= cr_lft_d;
         cf_rht_q   <= cf_rht_d;
         cr_rht_q   <= cr_rht_d;
         lft_meas_q <= lft_meas_d;
         rht_meas_q <= rht_meas_d;
         brk_lft_q  <= brk_lft_d;
         brk_rht_q  <= brk_rht_d;
         flt_lft_q  <= flt_lft_d;
         flt_rht_q  <= flt_rht_d;
         vld_q      <= vld_d;
      end
   end

   assign bus.lft_meas = lft_meas_q;
   assign bus.rht_meas = rht_meas_q;
   assign bus.brk_lft  = brk_lft_q;
   assign bus.brk_rht  = brk_rht_q;
   assign bus.flt_lft  = flt_lft_q;
   assign bus.flt_rht  = flt_rht_q;
   assign bus.meas_vld = vld_q;
endmodule

// File: tb/tb_motor_drive_monitor.sv
// Bench for motor_drive_monitor: PWM windows driven in lockstep with the DUT
// windows, expected window results queued and matched when meas_vld fires.
module tb_motor_drive_monitor;
   localparam int unsigned P = 1024;

   typedef struct packed {
      logic [10:0] lm;
      logic [10:0] rm;
      logic        bl;
      logic        br;
      logic        fl;
      logic        fr;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   vld_cnt = 0;
   bit   prev_vld = 1'b0;
   exp_t sb[$];
   exp_t cur;
   exp_t mon_e;
   exp_t mon_got;

   always #5 clk = ~clk;

   motor_drive_monitor_if bus ();

   motor_drive_monitor #(.PERIOD(P)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic exp_t reset_exp();
      exp_t r;
      r.lm = '0; r.rm = '0; r.bl = 1'b1; r.br = 1'b1; r.fl = 1'b0; r.fr = 1'b0;
      return r;
   endfunction

   function automatic exp_t dut_out();
      exp_t r;
      r.lm = bus.lft_meas; r.rm = bus.rht_meas;
      r.bl = bus.brk_lft;  r.br = bus.brk_rht;
      r.fl = bus.flt_lft;  r.fr = bus.flt_rht;
      return r;
   endfunction

   // Reference classification of one side from its window counts.
   task automatic model_side(input int cf, input int cr, input logic [10:0] prev,
                             output logic [10:0] m, output logic b, output logic f);
      int mag;
      if (cf == int'(P) && cr == int'(P)) begin
         m = 11'd0; b = 1'b1; f = 1'b0;
      end else if (cr == 0) begin
         mag = (cf > 1023) ? 1023 : cf;
         m = 11'(mag); b = 1'b0; f = 1'b0;
      end else if (cf == 0) begin
         mag = (cr > 1023) ? 1023 : cr;
         m = 11'(2048 - mag); b = 1'b0; f = 1'b0;
      end else begin
         m = prev; b = 1'b0; f = 1'b1;
      end
   endtask

   task automatic push_exp(input int cfl, input int crl, input int cfr, input int crr);
      exp_t n;
      n = cur;
      model_side(cfl, crl, cur.lm, n.lm, n.bl, n.fl);
      model_side(cfr, crr, cur.rm, n.rm, n.br, n.fr);
      sb.push_back(n);
      cur = n;
   endtask

   // fwd pins high for the first n cycles of each period, rev pins for the last n.
   task automatic drive_cycles(input int nfl, input int nrl, input int nfr, input int nrr,
                               input int phase, input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         int p;
         p = (k + phase) % int'(P);
         bus.fwd_lft = (p < nfl);
         bus.rev_lft = (p >= int'(P) - nrl);
         bus.fwd_rht = (p < nfr);
         bus.rev_rht = (p >= int'(P) - nrr);
         @(posedge clk); #1;
      end
   endtask

   task automatic settle_point();
      @(negedge clk); #1;
   endtask

   task automatic start_meas();
      @(posedge clk); #1;
      bus.en = 1'b1;
      @(posedge clk); #1;
   endtask

   // Scoreboard: every meas_vld pulse consumes one expected window result.
   always @(negedge clk) begin
      if (bus.meas_vld === 1'b1) begin
         vld_cnt++;
         checks++;
         if (prev_vld) begin
            errors++;
            $display("FAIL vld_width: meas_vld high two cycles in a row");
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_vld: got meas_vld with nothing expected at %0t", $time);
         end else begin
            mon_e   = sb.pop_front();
            mon_got = dut_out();
            if (mon_got !== mon_e)
               $display("FAIL window_result: got lm=%h rm=%h bl=%b br=%b fl=%b fr=%b expected lm=%h rm=%h bl=%b br=%b fl=%b fr=%b",
                        mon_got.lm, mon_got.rm, mon_got.bl, mon_got.br, mon_got.fl, mon_got.fr,
                        mon_e.lm, mon_e.rm, mon_e.bl, mon_e.br, mon_e.fl, mon_e.fr);
            if (mon_got !== mon_e) errors++;
         end
      end
      prev_vld = (bus.meas_vld === 1'b1);
   end

   task automatic test_reset();
      exp_t got;
      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.fwd_lft = 1'b0; bus.rev_lft = 1'b0; bus.fwd_rht = 1'b0; bus.rev_rht = 1'b0;
      cur = reset_exp();
      repeat (3) @(posedge clk);
      #1;
      got = dut_out();
      checks++;
      if (got !== reset_exp()) begin
         errors++;
         $display("FAIL reset_values: got %h expected %h", got, reset_exp());
      end
      checks++;
      if (bus.meas_vld !== 1'b0) begin
         errors++;
         $display("FAIL reset_vld: got %b expected 0", bus.meas_vld);
      end
      rst_n = 1'b1;
      drive_cycles(400, 0, 0, 700, 0, 3 * int'(P));
      settle_point();
      got = dut_out();
      checks++;
      if (vld_cnt !== 0) begin
         errors++;
         $display("FAIL idle_no_vld: got %0d pulses expected 0", vld_cnt);
      end
      checks++;
      if (got !== reset_exp()) begin
         errors++;
         $display("FAIL idle_outputs: got %h expected %h", got, reset_exp());
      end
   endtask

   task automatic test_fwd_duty();
      int c0;
      start_meas();
      c0 = vld_cnt;
      drive_cycles(300, 0, 0, 0, 37, int'(P));
      settle_point();
      checks++;
      if (vld_cnt !== c0) begin
         errors++;
         $display("FAIL settle_no_vld: got %0d pulses expected %0d", vld_cnt, c0);
      end
      push_exp(300, 0, 0, 0);
      drive_cycles(300, 0, 0, 0, 37, int'(P));
      settle_point();
      checks++;
      if (vld_cnt !== c0 + 1) begin
         errors++;
         $display("FAIL first_vld_timing: got %0d pulses expected %0d", vld_cnt, c0 + 1);
      end
   endtask

   task automatic test_rev_duty();
      int c0;
      c0 = vld_cnt;
      push_exp(300, 0, 0, 511);
      drive_cycles(300, 0, 0, 511, 613, int'(P));
      settle_point();
      checks++;
      if (bus.rht_meas !== 11'h601 || vld_cnt !== c0 + 1) begin
         errors++;
         $display("FAIL rev_511: got rht_meas=%h pulses=%0d expected 601 pulses=%0d",
                  bus.rht_meas, vld_cnt, c0 + 1);
      end
   endtask

   task automatic test_brake_sat();
      int c0;
      c0 = vld_cnt;
      push_exp(1024, 1024, 700, 0);
      drive_cycles(1024, 1024, 700, 0, 5, int'(P));
      settle_point();
      push_exp(1024, 0, 0, 1024);
      drive_cycles(1024, 0, 0, 1024, 0, int'(P));
      settle_point();
      checks++;
      if (bus.lft_meas !== 11'd1023 || bus.rht_meas !== 11'h401 || vld_cnt !== c0 + 2) begin
         errors++;
         $display("FAIL saturate: got lft=%h rht=%h pulses=%0d expected 3ff 401 pulses=%0d",
                  bus.lft_meas, bus.rht_meas, vld_cnt, c0 + 2);
      end
   endtask

   task automatic test_fault();
      int c0;
      c0 = vld_cnt;
      push_exp(100, 50, 0, 0);
      drive_cycles(100, 50, 0, 0, 0, int'(P));
      settle_point();
      checks++;
      if (bus.flt_lft !== 1'b1 || bus.lft_meas !== 11'd1023) begin
         errors++;
         $display("FAIL fault_hold: got flt=%b lft=%h expected flt=1 lft=3ff",
                  bus.flt_lft, bus.lft_meas);
      end
      push_exp(200, 0, 0, 0);
      drive_cycles(200, 0, 0, 0, 0, int'(P));
      settle_point();
      checks++;
      if (vld_cnt !== c0 + 2) begin
         errors++;
         $display("FAIL fault_windows: got %0d pulses expected %0d", vld_cnt, c0 + 2);
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = vld_cnt;
      for (int i = 0; i < 5; i++) begin
         int a, b, c, d, ph;
         a  = int'($urandom_range(0, P));
         b  = (i % 2 == 0) ? 0 : int'($urandom_range(0, P));
         c  = (i % 3 == 0) ? int'($urandom_range(1, P)) : 0;
         d  = int'($urandom_range(0, P));
         ph = int'($urandom_range(0, P - 1));
         push_exp(a, b, c, d);
         drive_cycles(a, b, c, d, ph, int'(P));
      end
      settle_point();
      checks++;
      if (vld_cnt !== c0 + 5 || sb.size() != 0) begin
         errors++;
         $display("FAIL back_to_back: got %0d pulses, %0d pending expected %0d pulses, 0 pending",
                  vld_cnt, sb.size(), c0 + 5);
      end
   endtask

   task automatic test_abort();
      int   c0;
      exp_t got;
      c0 = vld_cnt;
      drive_cycles(900, 0, 0, 0, 0, 500);
      bus.en = 1'b0;
      drive_cycles(900, 0, 0, 0, 500, 2 * int'(P) + 10);
      settle_point();
      got = dut_out();
      checks++;
      if (vld_cnt !== c0 || got !== cur) begin
         errors++;
         $display("FAIL abort_hold: got pulses=%0d out=%h expected pulses=%0d out=%h",
                  vld_cnt, got, c0, cur);
      end
      start_meas();
      drive_cycles(420, 0, 0, 0, 11, int'(P));
      settle_point();
      checks++;
      if (vld_cnt !== c0) begin
         errors++;
         $display("FAIL restart_settle: got %0d pulses expected %0d", vld_cnt, c0);
      end
      push_exp(420, 0, 0, 33);
      drive_cycles(420, 0, 0, 33, 11, int'(P));
      settle_point();
      checks++;
      if (vld_cnt !== c0 + 1) begin
         errors++;
         $display("FAIL restart_vld: got %0d pulses expected %0d", vld_cnt, c0 + 1);
      end
      drive_cycles(420, 0, 0, 33, 11, 300);
      rst_n = 1'b0;
      cur = reset_exp();
      #2;
      got = dut_out();
      checks++;
      if (got !== reset_exp() || bus.meas_vld !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got out=%h vld=%b expected out=%h vld=0",
                  got, bus.meas_vld, reset_exp());
      end
      bus.en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive_cycles(0, 0, 0, 0, 0, 20);
   endtask

   initial begin
      test_reset();
      test_fwd_duty();
      test_rev_duty();
      test_brake_sat();
      test_fault();
      test_back_to_back();
      test_abort();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
